// File: rtl/fpu_pkg.sv
// Shared opcodes, sequencer state encoding and latency lookup for the FPU front end.
package fpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_MUL  = 4'h2;
    localparam logic [OP_W-1:0] OP_DIV  = 4'h3;
    localparam logic [OP_W-1:0] OP_AND  = 4'h4;
    localparam logic [OP_W-1:0] OP_OR   = 4'h5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h7;
    localparam logic [OP_W-1:0] OP_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Opcodes 0..7 map onto an execution unit; everything above is rejected.
    function automatic logic op_supported(input logic [OP_W-1:0] op);
        return (op[OP_W-1] == 1'b0);
    endfunction

    // Latency of the unit selected by op; module parameters are passed in.
    function automatic logic [CNT_W-1:0] lat_of(
        input logic [OP_W-1:0]  op,
        input logic [CNT_W-1:0] addsub_lat,
        input logic [CNT_W-1:0] mul_lat,
        input logic [CNT_W-1:0] div_lat,
        input logic [CNT_W-1:0] logic_lat
    );
        case (op)
            OP_ADD, OP_SUB: return addsub_lat;
            OP_MUL:         return mul_lat;
            OP_DIV:         return div_lat;
            default:        return logic_lat;
        endcase
    endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter that times how long a unit is held selected.
module fpu_lat_counter
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fpu_op_sequencer.sv
// Single-issue sequencer: issues one op to the shared unit bus, waits its latency, returns the result.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned ADDSUB_LAT = 3,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned DIV_LAT    = 8,
    parameter int unsigned LOGIC_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    output logic [OP_W-1:0]   unit_op,
    input  logic [DATA_W-1:0] unit_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [OP_W-1:0]   out_op,
    output logic              out_err,
    output logic              busy
);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [OP_W-1:0]   unit_op_q, unit_op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;

    fpu_lat_counter u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign in_ready = (state_q == IDLE) && !rst;

    // Next-state and datapath update; unit_op is only ever non-idle while in EXEC.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        unit_op_d    = unit_op_q;
        res_d        = res_q;
        out_op_d     = out_op_q;
        err_d        = err_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        cnt_load     = 1'b0;
        cnt_load_val = lat_of(in_op, CNT_W'(ADDSUB_LAT), CNT_W'(MUL_LAT),
                              CNT_W'(DIV_LAT), CNT_W'(LOGIC_LAT)) - CNT_W'(1);
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d    = in_a;
                    b_d    = in_b;
                    op_d   = in_op;
                    busy_d = 1'b1;
                    if (op_supported(in_op)) begin
                        cnt_load  = 1'b1;
                        unit_op_d = in_op;
                        state_d   = EXEC;
                    end else begin
                        res_d       = '0;
                        out_op_d    = in_op;
                        err_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            EXEC: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    res_d       = unit_result;
                    out_op_d    = op_q;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    unit_op_d   = OP_NONE;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                unit_op_d   = OP_NONE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            unit_op_q   <= OP_NONE;
            res_q       <= '0;
            out_op_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            unit_op_q   <= unit_op_d;
            res_q       <= res_d;
            out_op_q    <= out_op_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign unit_op    = unit_op_q;
    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign out_op     = out_op_q;
    assign out_err    = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer with a latency-aware model of the shared result bus.
module tb_fpu_op_sequencer;
    import fpu_pkg::*;

    localparam int unsigned ADDSUB_LAT = 3;
    localparam int unsigned MUL_LAT    = 4;
    localparam int unsigned DIV_LAT    = 8;
    localparam int unsigned LOGIC_LAT  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_op;
    logic [31:0] unit_a, unit_b;
    logic [3:0]  unit_op;
    wire  [31:0] unit_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_op;
    logic        out_err;
    logic        busy;

    fpu_op_sequencer #(
        .ADDSUB_LAT (ADDSUB_LAT),
        .MUL_LAT    (MUL_LAT),
        .DIV_LAT    (DIV_LAT),
        .LOGIC_LAT  (LOGIC_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_op     (unit_op),
        .unit_result (unit_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_op      (out_op),
        .out_err     (out_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: latency and arithmetic per opcode.
    function automatic int unsigned ref_lat(input logic [3:0] op);
        case (op)
            4'd0, 4'd1:             return ADDSUB_LAT;
            4'd2:                   return MUL_LAT;
            4'd3:                   return DIV_LAT;
            4'd4, 4'd5, 4'd6, 4'd7: return LOGIC_LAT;
            default:                return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return ~a;
            default: return 32'h0;
        endcase
    endfunction

    // Bus model: selected unit drives garbage until its latency elapses, high-Z when nothing is selected.
    int unsigned ex_cnt = 0;
    always @(posedge clk) begin
        if (unit_op == OP_NONE) ex_cnt <= 0;
        else                    ex_cnt <= ex_cnt + 1;
    end
    assign unit_result = (unit_op[3] == 1'b0)
                       ? ((ex_cnt == ref_lat(unit_op) - 1) ? ref_calc(unit_op, unit_a, unit_b) : 32'hDEAD_BEEF)
                       : 32'hzzzz_zzzz;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int unsigned due;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: samples 2ns after each rising edge and checks against the scoreboard.
    logic        held = 1'b0;
    logic [31:0] h_res;
    logic [3:0]  h_op;
    logic        h_err;
    int unsigned exec_seen = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                if (!busy) exec_seen = 0;
                if (unit_op != OP_NONE) begin
                    exec_seen++;
                    if (sb.size() == 0) begin
                        chk("unit_op_unexpected", 32'(unit_op), 32'(OP_NONE));
                    end else begin
                        chk("unit_op", 32'(unit_op), 32'(sb[0].op));
                        chk("unit_a", unit_a, sb[0].a);
                        chk("unit_b", unit_b, sb[0].b);
                        chk("in_ready_exec", 32'(in_ready), 32'd0);
                    end
                end
                if (out_valid) begin
                    chk("unit_op_in_done", 32'(unit_op), 32'(OP_NONE));
                    chk("in_ready_done", 32'(in_ready), 32'd0);
                    if (!held) begin
                        held  = 1'b1;
                        h_res = out_result;
                        h_op  = out_op;
                        h_err = out_err;
                        if (sb.size() == 0) begin
                            n_chk++;
                            $display("FAIL unexpected_result: got op %h res %h, expected none (cycle %0d)", out_op, out_result, cyc);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            chk("out_result", out_result, e.res);
                            chk("out_op", 32'(out_op), 32'(e.op));
                            chk("out_err", 32'(out_err), 32'(e.err));
                            chk("latency", 32'(cyc), 32'(e.due));
                            chk("exec_cycles", 32'(exec_seen), 32'(e.lat));
                        end
                        exec_seen = 0;
                    end else begin
                        chk("stall_result", out_result, h_res);
                        chk("stall_op", 32'(out_op), 32'(h_op));
                        chk("stall_err", 32'(out_err), 32'(h_err));
                    end
                end else begin
                    held = 1'b0;
                end
            end else begin
                held      = 1'b0;
                exec_seen = 0;
            end
        end
    end

    // out_ready driver: random unless a directed test takes control.
    logic or_rand = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (or_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    int unsigned last_acc = 0;

    // Present a request from a negedge and wait (bounded) for acceptance; records the expected response.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        for (int w = 0; ; w++) begin
            #1;
            if (in_ready) break;
            if (w >= 300) begin
                n_chk++;
                $display("FAIL accept_timeout: in_ready stayed %b, expected 1 (cycle %0d)", in_ready, cyc);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.err = (op > 4'd7);
        e.res = e.err ? 32'h0 : ref_calc(op, a, b);
        e.lat = ref_lat(op);
        e.due = cyc + 1 + e.lat;
        sb.push_back(e);
        last_acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int w = 0; ; w++) begin
            @(negedge clk);
            #1;
            if (!busy && (sb.size() == 0)) break;
            if (w >= 400) begin
                n_chk++;
                $display("FAIL idle_timeout: busy %b queue %0d, expected idle and empty (cycle %0d)", busy, sb.size(), cyc);
                sb.delete();
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hs;
        logic        seen;
        logic [3:0]  op;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_unit_op", 32'(unit_op), 32'hF);
        chk("rst_unit_a", unit_a, 32'h0);
        chk("rst_unit_b", unit_b, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // XOR, single-cycle unit.
        issue(4'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        wait_idle();

        // DIV, longest latency.
        issue(4'd3, $urandom, $urandom_range(1, 1000));
        wait_idle();

        // Unsupported opcode.
        issue(4'd9, $urandom, $urandom);
        wait_idle();

        // Back-pressure on ADD completion.
        out_ready = 1'b0;
        issue(4'd0, $urandom, $urandom);
        seen = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_out_valid_seen", 32'(seen), 32'd1);
        in_valid = 1'b1;
        in_op    = OP_AND;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        hs = cyc + 1;
        @(negedge clk);
        issue(OP_AND, $urandom, $urandom);
        chk("bp_next_accept", 32'(last_acc), 32'(hs + 1));
        wait_idle();

        // Reset in the third EXEC cycle of MUL.
        issue(4'd2, $urandom, $urandom);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_unit_op", 32'(unit_op), 32'hF);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        repeat (10) @(negedge clk);

        // Back-to-back ADD then AND.
        issue(4'd0, $urandom, $urandom);
        issue(4'd4, $urandom, $urandom);
        wait_idle();

        // Randomized traffic with random back-pressure.
        or_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(8, 15));
            else                            op = 4'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, $urandom, (op == 4'd3 && $urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
        end
        wait_idle();
        or_rand = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
